axi_window_dumper: RTL

//  Parametrised AXI4 read-burst engine that dumps a contiguous window region from the

---
 rtl/axi_dump_pkg.sv | 16 +
 rtl/axi_window_dumper_if.sv | 25 ++
 rtl/axi_dump_beat_fifo.sv | 49 ++++
 rtl/axi_window_dumper.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_dump_pkg.sv
// Shared FSM encoding, AXI constants and frame bytes for the AXI window dumper.
package axi_dump_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_RECV, ST_DRAIN, ST_DONE} dump_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [7:0] FRAME_SYNC0    = 8'hA5;
   localparam logic [7:0] FRAME_SYNC1    = 8'h5A;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/axi_window_dumper_if.sv
// AXI4 read-address and read-data channels between the dumper (master) and the RAM (slave).
interface axi_window_dumper_if #(parameter int DATA_BYTE_WIDTH = 32);
   logic [3:0]                   axi_arid;
   logic [31:0]                  axi_araddr;
   logic [7:0]                   axi_arlen;
   logic [2:0]                   axi_arsize;
   logic [1:0]                   axi_arburst;
   logic                         axi_arvalid;
   logic                         axi_arready;
   logic [3:0]                   axi_rid;
   logic [DATA_BYTE_WIDTH*8-1:0] axi_rdata;
   logic [1:0]                   axi_rresp;
   logic                         axi_rlast;
   logic                         axi_rvalid;
   logic                         axi_rready;

   modport master (
      output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
      input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
   );
   modport slave (
      input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
      output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
   );
endinterface

// File: rtl/axi_dump_beat_fifo.sv
// Show-ahead synchronous beat FIFO with full/empty flags and a free-slot count.
module axi_dump_beat_fifo #(
   parameter int WIDTH = 256,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_free
);
   localparam int          DEPTH   = 1 << AW;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [AW:0]      r_cnt;
   logic             w_do_push, w_do_pop;

   assign o_full    = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign o_free    = (AW+1)'(DEPTH) - r_cnt;
   assign o_rdata   = r_mem[r_rd];
   // a full FIFO still accepts a push when the same cycle pops
   assign w_do_push = i_push && (!o_full || i_pop);
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + PTR_ONE;
         if (w_do_pop)  r_rd <= r_rd + PTR_ONE;
         if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + CNT_ONE;
         else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - CNT_ONE;
      end
   end
endmodule

// File: rtl/axi_window_dumper.sv
// AXI4 burst reader that streams a RAM window out as bytes, LSB first.
// Build option DUMP_FRAME_EN wraps each dump in A5 5A len16 ... xor framing.
module axi_window_dumper
   import axi_dump_pkg::*;
#(
   parameter int         DATA_BYTE_WIDTH  = 32,
   parameter int         TOTAL_BEATS      = 416,
   parameter int         BURST_LEN        = 16,
   parameter int         FIFO_DEPTH_INDEX = 5,
   parameter logic [3:0] AXI_ID           = 4'h0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [31:0]         start_addr,
   output logic                busy,
   output logic                done,
   output logic                resp_err,
   axi_window_dumper_if.master axi,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready
);
   localparam int          W           = DATA_BYTE_WIDTH;
   localparam int          BW          = W * 8;
   localparam int          BURST_BYTES = BURST_LEN * W;
   localparam int          FIRST_LEN   = (TOTAL_BEATS < BURST_LEN) ? TOTAL_BEATS : BURST_LEN;
   localparam logic [31:0] ADDR_MASK   = ~((32'd1 << clog2(BURST_BYTES)) - 32'd1);
   localparam logic [15:0] TOT16       = 16'(TOTAL_BEATS);

   dump_state_t       r_state, w_next;
   logic [31:0]       r_araddr;
   logic [7:0]        r_arlen;
   logic [15:0]       r_beats_left, w_nlen;
   logic [8:0]        r_burst_left;
   logic              r_resp_err, r_tx_valid;
   logic [7:0]        r_tx_data, r_sh_cnt, w_byte, w_hdr_byte, w_trl_byte;
   logic [BW-1:0]     r_sh, w_fifo_rdata;
   logic [FIFO_DEPTH_INDEX:0] w_free;
   logic w_arvalid, w_rready, w_ar_hs, w_push, w_last_beat, w_full, w_empty, w_active;
   logic w_ld, w_bvld, w_pop, w_from_sh, w_hdr_adv, w_trl_ld, w_fin;
   logic w_hdr_pend, w_trl_rdy, w_trl_wait, w_unused;

   axi_dump_beat_fifo #(.WIDTH(BW), .AW(FIFO_DEPTH_INDEX)) u_fifo (
      .clk(clk), .rst(rst), .i_push(w_push), .i_wdata(axi.axi_rdata), .i_pop(w_pop),
      .o_rdata(w_fifo_rdata), .o_full(w_full), .o_empty(w_empty), .o_free(w_free)
   );

   assign w_ar_hs     = w_arvalid && axi.axi_arready;
   assign w_push      = axi.axi_rvalid && w_rready;
   assign w_last_beat = w_push && (r_burst_left == 9'd1);
   assign w_nlen      = (r_beats_left > 16'(BURST_LEN)) ? 16'(BURST_LEN) : r_beats_left;
   assign w_active    = (r_state == ST_ISSUE) || (r_state == ST_RECV) || (r_state == ST_DRAIN);
   assign w_fin       = w_empty && (r_sh_cnt == '0) && !w_trl_wait && (!r_tx_valid || tx_ready);

   always_comb begin
      w_next    = r_state;
      w_arvalid = 1'b0;
      w_rready  = 1'b0;
      unique case (r_state)
         ST_IDLE:  if (start) w_next = ST_ISSUE;
         ST_ISSUE: begin
            // only ask for a burst the FIFO can fully absorb
            w_arvalid = (32'(w_free) >= 32'(r_arlen) + 32'd1);
            if (w_ar_hs) w_next = ST_ISSUE == ST_ISSUE ? ST_RECV : ST_RECV;
         end
         ST_RECV: begin
            w_rready = !w_full;
            if (w_last_beat) w_next = (r_beats_left != '0) ? ST_ISSUE : ST_DRAIN;
         end
         ST_DRAIN: if (w_fin) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_araddr     <= '0;
         r_arlen      <= '0;
         r_beats_left <= '0;
         r_burst_left <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && start) begin
            r_araddr     <= start_addr & ADDR_MASK;
            r_arlen      <= 8'(FIRST_LEN - 1);
            r_beats_left <= 16'(TOTAL_BEATS - FIRST_LEN);
            r_resp_err   <= 1'b0;
         end
         if (w_ar_hs) r_burst_left <= 9'(r_arlen) + 9'd1;
         if (w_push) begin
            r_burst_left <= r_burst_left - 9'd1;
            if (axi.axi_rresp != AXI_RESP_OKAY) r_resp_err <= 1'b1;
            // burst end is counted locally; rlast is not trusted for control
            if (r_burst_left == 9'd1 && r_beats_left != '0) begin
               r_araddr     <= r_araddr + 32'(BURST_BYTES);
               r_arlen      <= 8'(w_nlen - 16'd1);
               r_beats_left <= r_beats_left - w_nlen;
            end
         end
      end
   end

   // byte source priority: header, current beat, next FIFO beat, trailer
   assign w_ld = w_active && (!r_tx_valid || tx_ready);
   always_comb begin
      w_pop = 1'b0; w_from_sh = 1'b0; w_hdr_adv = 1'b0; w_trl_ld = 1'b0;
      w_bvld = 1'b0; w_byte = '0;
      if (w_ld) begin
         if (w_hdr_pend) begin
            w_bvld = 1'b1; w_byte = w_hdr_byte; w_hdr_adv = 1'b1;
         end else if (r_sh_cnt != '0) begin
            w_bvld = 1'b1; w_byte = r_sh[7:0]; w_from_sh = 1'b1;
         end else if (!w_empty) begin
            w_bvld = 1'b1; w_byte = w_fifo_rdata[7:0]; w_pop = 1'b1;
         end else if (w_trl_rdy) begin
            w_bvld = 1'b1; w_byte = w_trl_byte; w_trl_ld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_sh       <= '0;
         r_sh_cnt   <= '0;
      end else begin
         if (w_ld) begin
            r_tx_valid <= w_bvld;
            if (w_bvld) r_tx_data <= w_byte;
         end
         if (w_pop) begin
            r_sh     <= w_fifo_rdata >> 8;
            r_sh_cnt <= 8'(W - 1);
         end else if (w_from_sh) begin
            r_sh     <= r_sh >> 8;
            r_sh_cnt <= r_sh_cnt - 8'd1;
         end
      end
   end

`ifdef DUMP_FRAME_EN
   logic [2:0]  r_hdr_idx;
   logic [15:0] r_pops_left;
   logic        r_trl_pend;
   logic [7:0]  r_xor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hdr_idx   <= '0;
         r_pops_left <= '0;
         r_trl_pend  <= 1'b0;
         r_xor       <= '0;
      end else if (r_state == ST_IDLE && start) begin
         r_hdr_idx   <= '0;
         r_pops_left <= TOT16;
         r_trl_pend  <= 1'b1;
         r_xor       <= '0;
      end else begin
         if (w_hdr_adv) r_hdr_idx <= r_hdr_idx + 3'd1;
         if (w_pop) r_pops_left <= r_pops_left - 16'd1;
         if (w_pop || w_from_sh) r_xor <= r_xor ^ w_byte;
         if (w_trl_ld) r_trl_pend <= 1'b0;
      end
   end

   always_comb begin
      w_hdr_byte = FRAME_SYNC0;
      case (r_hdr_idx)
         3'd1:    w_hdr_byte = FRAME_SYNC1;
         3'd2:    w_hdr_byte = TOT16[7:0];
         3'd3:    w_hdr_byte = TOT16[15:8];
         default: w_hdr_byte = FRAME_SYNC0;
      endcase
   end
   assign w_hdr_pend = (r_hdr_idx != 3'd4);
   assign w_trl_rdy  = r_trl_pend && (r_pops_left == '0);
   assign w_trl_wait = r_trl_pend;
   assign w_trl_byte = r_xor;
`else
   assign w_hdr_byte = '0;
   assign w_hdr_pend = 1'b0;
   assign w_trl_rdy  = 1'b0;
   assign w_trl_wait = 1'b0;
   assign w_trl_byte = '0;
`endif

   assign w_unused = ^{axi.axi_rid, axi.axi_rlast, w_hdr_adv, w_trl_ld, TOT16};

   assign busy             = (r_state != ST_IDLE);
   assign done             = (r_state == ST_DONE);
   assign resp_err         = r_resp_err;
   assign tx_valid         = r_tx_valid;
   assign tx_data          = r_tx_data;
   assign axi.axi_arid     = AXI_ID;
   assign axi.axi_araddr   = r_araddr;
   assign axi.axi_arlen    = r_arlen;
   assign axi.axi_arsize   = 3'(clog2(W));
   assign axi.axi_arburst  = AXI_BURST_INCR;
   assign axi.axi_arvalid  = w_arvalid;
   assign axi.axi_rready   = w_rready;
endmodule
